// File: rtl/serial_slt_unit.sv
// rtl/serial_slt_unit.sv - bit-serial set-less-than comparator (slt/sltu)
// One full-adder step per cycle, LSB first, computing a + ~b + 1.
module serial_slt_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             lt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CNT_W-1:0] cnt;
  logic             sgn;
  logic             carry;
  logic             lt_q;
  logic             sum;
  logic             carry_nxt;
  logic             last;
  logic             accept;

  // One subtract step on the current LSBs: a0 + ~b0 + carry.
  always_comb begin
    sum       = a_sh[0] ^ ~b_sh[0] ^ carry;
    carry_nxt = (a_sh[0] & ~b_sh[0]) | (a_sh[0] & carry) | (~b_sh[0] & carry);
    last      = (cnt == LAST);
    accept    = start && (state != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
      carry <= 1'b0;
      lt_q  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      sgn   <= is_signed;
      carry <= 1'b1;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= carry_nxt;
      if (last) begin
        // Signed: sign of difference corrected by overflow (carry into MSB ^ carry out).
        lt_q <= sgn ? (sum ^ (carry ^ carry_nxt)) : ~carry_nxt;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign lt   = lt_q;

endmodule

// File: tb/tb_serial_slt_unit.sv
// tb/tb_serial_slt_unit.sv - self-checking bench for serial_slt_unit
// Directed corners plus random compares against an arithmetic reference.
module tb_serial_slt_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         is_signed = 1'b0;
  logic         busy;
  logic         done;
  logic         lt;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;

  serial_slt_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .lt        (lt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic ref_lt(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    if (s) return ($signed(x) < $signed(y));
    return (x < y);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sync=1: present the request at the next falling edge; sync=0: present it now.
  // inject>=0: raise a second start with other operands at that RUN cycle.
  task automatic do_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input bit sync, input int inject, input string tag,
                        output int done_cyc);
    int   lat;
    int   busy_cnt;
    logic prev_lt;
    logic lt_stable;
    logic exp_lt;
    exp_lt = ref_lt(ta, tb_v, ts);
    if (sync) @(negedge clk);
    a = ta; b = tb_v; is_signed = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
    prev_lt   = lt;
    lt_stable = 1'b1;
    lat       = 0;
    busy_cnt  = 0;
    while (!done && lat < W + 8) begin
      if (busy) busy_cnt++;
      if (lt !== prev_lt) lt_stable = 1'b0;
      if (lat == inject) begin
        start = 1'b1; a = 9; b = 3; is_signed = 1'b0;
      end else if (lat == inject + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start    = 1'b0;
    done_cyc = cyc;
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(W));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    chk({tag, "_lt_stable"}, 32'(lt_stable), 32'd1);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, "_lt"}, 32'(lt), 32'(exp_lt));
  endtask

  task automatic pulse_end(input string tag);
    @(posedge clk); #1;
    chk({tag, "_single_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int   dc1, dc2;
    logic saw_done;
    logic [W-1:0] ra, rb;
    logic rs;

    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_lt", 32'(lt), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_cmp(32'd5, 32'd7, 1'b0, 1'b1, -1, "u_5_7", dc1);            pulse_end("u_5_7");
    do_cmp(32'd7, 32'd5, 1'b0, 1'b1, -1, "u_7_5", dc1);            pulse_end("u_7_5");
    do_cmp(32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, -1, "u_neg1_1", dc1);  pulse_end("u_neg1_1");
    do_cmp(32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, -1, "s_neg1_1", dc1);  pulse_end("s_neg1_1");
    do_cmp(32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, -1, "s_max_min", dc1); pulse_end("s_max_min");
    do_cmp(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, -1, "s_min_max", dc1); pulse_end("s_min_max");
    do_cmp(32'h80000000, 32'h80000000, 1'b1, 1'b1, -1, "s_min_eq", dc1);  pulse_end("s_min_eq");

    // Start during RUN is ignored, then a back-to-back request in the DONE cycle.
    do_cmp(32'd1, 32'd2, 1'b0, 1'b1, 10, "busy_prot", dc1);
    do_cmp(32'd3, 32'd3, 1'b0, 1'b0, -1, "b2b_eq", dc2);
    chk("b2b_spacing", 32'(dc2 - dc1), 32'(W + 1));
    pulse_end("b2b_eq");

    do_cmp(32'd2, 32'd9, 1'b0, 1'b1, -1, "pre_reset", dc1); pulse_end("pre_reset");

    // Asynchronous reset between clock edges during RUN.
    @(negedge clk);
    a = 32'd0; b = 32'd1; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_lt", 32'(lt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (W + 6) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("rst_no_done", 32'(saw_done), 32'd0);
    chk("rst_lt_after", 32'(lt), 32'd0);
    do_cmp(32'd0, 32'd1, 1'b0, 1'b1, -1, "post_reset", dc1); pulse_end("post_reset");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rs = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (32'd1 << $urandom_range(0, W - 1));
        default: ;
      endcase
      do_cmp(ra, rb, rs, 1'b1, -1, $sformatf("rnd%0d", i), dc1);
      pulse_end($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_slt_unit.md
Name: serial_slt_unit

Overview:
- Multi-cycle set-less-than comparator for the ALU slt/sltu path.
- Computes a < b bit-serially, LSB first, using a one-bit subtract chain (a + ~b + 1).
- Produces a single result bit, lt. That bit goes directly into the downstream 1-bit-to-32-bit zero-extend stage, which forms the register write value.
- Trades latency for area: one full-adder cell per cycle instead of a WIDTH-bit carry chain.

Parameters:
- WIDTH, 32, operand width in bits; must be >= 2.
- CNT_W, 6, bit counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a compare; sampled on rising clk
- a  input  WIDTH  left operand; captured when start is accepted
- b  input  WIDTH  right operand; captured when start is accepted
- is_signed  input  1  1 = slt (two's complement), 0 = sltu; captured with operands
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse: lt is valid
- lt  output  1  compare result; held until the next accepted start completes

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy=0; done=0; lt=0; counter, carry and shift registers cleared.
  - Reset asserted mid-RUN aborts the operation. No done pulse is produced. lt reads 0 after release.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0.
    - start=1: load a_sh<=a, b_sh<=b, sgn<=is_signed, carry<=1, cnt<=0; go to RUN.
  - RUN: busy=1, done=0.
    - Each edge processes bit 0 of the shift registers: s = a0 ^ ~b0 ^ carry; carry <= majority(a0, ~b0, carry).
    - a_sh and b_sh shift right by 1; cnt increments.
    - On the edge processing bit WIDTH-1:
      - capture c_in_msb = carry before update, c_out = carry after update, s_msb = s.
      - lt <= sgn ? (s_msb ^ (c_in_msb ^ c_out)) : ~c_out
      - go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle.
    - start=1 here is accepted exactly as in IDLE, giving back-to-back operation.
    - Otherwise go to IDLE.
- start is ignored while in RUN. Operands presented then are not captured.
- Latency:
  - start sampled at edge E0.
  - RUN covers edges E1..E_WIDTH.
  - done high in the cycle after E_WIDTH, i.e. WIDTH cycles after the accepting edge.
  - Throughput: one compare per WIDTH+1 cycles.
- lt changes only on the final RUN edge or on reset. It is stable while busy=1 and keeps the previous result.
- a and b may change freely after capture; the result depends only on the captured values.
- Equal operands give lt=0 in both modes (c_out=1, sum=0, no overflow).
- Counter wrap is unreachable: cnt is cleared on each accept and stops at WIDTH-1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Unsigned basic: a=5, b=7, is_signed=0, start pulse.
  - Required: busy=1 for 32 cycles; done pulses WIDTH cycles after the accept edge; lt=1.
  - Repeat with a=7, b=5: lt=0.
- Sign sensitivity: a=0xFFFFFFFF, b=0x00000001.
  - is_signed=0: lt=0.
  - is_signed=1: lt=1.
- Overflow corners, signed mode:
  - a=0x7FFFFFFF, b=0x80000000: lt=0.
  - a=0x80000000, b=0x7FFFFFFF: lt=1.
  - a=b=0x80000000: lt=0.
- Busy protection: start a=1, b=2 (unsigned).
  - Mid-RUN, assert start with a=9, b=3.
  - Required: second request ignored; single done pulse; lt=1.
  - Then back-to-back start in the DONE cycle with a=3, b=3: second done exactly WIDTH+1 cycles after the first; lt=0.
- Reset mid-operation: start a=0, b=1; drop rst_n at RUN cycle 10 asynchronously, between clock edges.
  - Required: busy, done and lt go to 0 immediately; no done pulse after release.
  - A fresh start then completes normally with lt=1.
